// File: rtl/ucca_pkg.sv
// rtl/ucca_pkg.sv - UCC state encodings and reset vector shared with the stack monitor
package ucca_pkg;

  typedef enum logic [1:0] {
    UCC_NOT = 2'b00,
    UCC_IN  = 2'b01,
    UCC_IRQ = 2'b10,
    UCC_RST = 2'b11
  } ucc_state_e;

  localparam logic [15:0] RESET_HANDLER_DEFAULT = 16'h0000;

endpackage

// File: rtl/ucc_entry_fsm_if.sv
// rtl/ucc_entry_fsm_if.sv - pc/irq/bounds inputs and status outputs of the UCC entry FSM
interface ucc_entry_fsm_if;

  logic [15:0] pc;
  logic        irq;
  logic [15:0] ucc_min;
  logic [15:0] ucc_max;
  logic [1:0]  ucc_state;
  logic        outside_ucc;
  logic        inst_changed;
  logic        exec_reset;

  modport master (
    output pc, irq, ucc_min, ucc_max,
    input  ucc_state, outside_ucc, inst_changed, exec_reset
  );

  modport slave (
    input  pc, irq, ucc_min, ucc_max,
    output ucc_state, outside_ucc, inst_changed, exec_reset
  );

endinterface

// File: rtl/ucc_region_cmp.sv
// rtl/ucc_region_cmp.sv - inclusive unsigned bounds compare; an inverted range is empty
module ucc_region_cmp (
  input  logic [15:0] pc,
  input  logic [15:0] ucc_min,
  input  logic [15:0] ucc_max,
  output logic        outside_ucc
);

  assign outside_ucc = (pc < ucc_min) | (pc > ucc_max);

endmodule

// File: rtl/ucc_entry_fsm.sv
// rtl/ucc_entry_fsm.sv - tracks legal entry, exit and interrupt return of the UCC region
module ucc_entry_fsm
  import ucca_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEFAULT
) (
  input  logic           clk,
  input  logic           system_reset,
  ucc_entry_fsm_if.slave bus
);

  ucc_state_e  state_q  = UCC_RST;
  ucc_state_e  state_d;
  logic [15:0] prev_pc  = 16'h0000;
  logic [15:0] saved_pc = 16'h0000;
  logic [15:0] saved_pc_d;
  logic        outside;

  ucc_region_cmp u_region_cmp (
    .pc          (bus.pc),
    .ucc_min     (bus.ucc_min),
    .ucc_max     (bus.ucc_max),
    .outside_ucc (outside)
  );

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q  <= UCC_RST;
      prev_pc  <= 16'h0000;
      saved_pc <= 16'h0000;
    end else begin
      state_q  <= state_d;
      prev_pc  <= bus.pc;
      saved_pc <= saved_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc;
    case (state_q)
      UCC_NOT: begin
        if (!outside) state_d = (bus.pc == bus.ucc_min) ? UCC_IN : UCC_RST;
      end
      UCC_IN: begin
        // Exit is legal only when the last in-region instruction was ucc_max
        if (outside) begin
          state_d = (prev_pc == bus.ucc_max) ? UCC_NOT : UCC_RST;
        end else if (bus.irq) begin
          state_d    = UCC_IRQ;
          saved_pc_d = bus.pc;
        end
      end
      UCC_IRQ: begin
        if (!outside) state_d = (bus.pc == saved_pc) ? UCC_IN : UCC_RST;
      end
      UCC_RST: begin
        if (bus.pc == RESET_HANDLER) state_d = UCC_NOT;
      end
      default: state_d = UCC_RST;
    endcase
  end

  assign bus.ucc_state    = state_q;
  assign bus.outside_ucc  = outside;
  assign bus.inst_changed = (bus.pc != prev_pc);
  assign bus.exec_reset   = (state_q == UCC_RST);

endmodule

// File: tb/tb_ucc_entry_fsm.sv
// tb/tb_ucc_entry_fsm.sv - vector table, corner sequences and randomized model check for ucc_entry_fsm
module tb_ucc_entry_fsm;

  localparam logic [1:0] S_NOT = 2'b00;
  localparam logic [1:0] S_IN  = 2'b01;
  localparam logic [1:0] S_IRQ = 2'b10;
  localparam logic [1:0] S_RST = 2'b11;

  typedef struct {
    logic        rst;
    logic        irq;
    logic [15:0] pc;
    logic [1:0]  st;
    logic        ex;
  } vec_t;

  logic clk = 1'b0;
  logic system_reset;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  m_state = S_RST;
  logic [15:0] m_prev  = 16'h0000;
  logic [15:0] m_saved = 16'h0000;
  logic [15:0] b_min, b_max;
  vec_t        vecs[$];

  ucc_entry_fsm_if u_if ();

  ucc_entry_fsm #(.RESET_HANDLER(16'h0000)) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .bus          (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc=%h t=%0t)", name, act, exp, u_if.pc, $time);
    end
  endtask

  function automatic logic in_region(input logic [15:0] p);
    return (p >= b_min) && (p <= b_max);
  endfunction

  // Reference: the region-entry rules read as plain decisions on where the pc is
  function automatic void model_step(input logic rst, input logic [15:0] p, input logic i);
    logic [1:0] nxt;
    if (rst) begin
      m_state = S_RST;
      m_prev  = 16'h0000;
      m_saved = 16'h0000;
      return;
    end
    nxt = m_state;
    if (m_state == S_RST) begin
      if (p == 16'h0000) nxt = S_NOT;
    end else if (m_state == S_NOT) begin
      if (in_region(p)) nxt = (p == b_min) ? S_IN : S_RST;
    end else if (m_state == S_IN) begin
      if (!in_region(p)) nxt = (m_prev == b_max) ? S_NOT : S_RST;
      else if (i) begin
        nxt     = S_IRQ;
        m_saved = p;
      end
    end else begin
      if (in_region(p)) nxt = (p == m_saved) ? S_IN : S_RST;
    end
    m_state = nxt;
    m_prev  = p;
  endfunction

  task automatic set_bounds(input logic [15:0] lo, input logic [15:0] hi);
    b_min = lo;
    b_max = hi;
    u_if.ucc_min = lo;
    u_if.ucc_max = hi;
  endtask

  task automatic cycle(input logic rst, input logic [15:0] p, input logic i);
    system_reset = rst;
    u_if.pc      = p;
    u_if.irq     = i;
    #1;
    chk("outside_ucc", 16'(u_if.outside_ucc), 16'(!in_region(p)));
    chk("inst_changed", 16'(u_if.inst_changed), 16'(p != m_prev));
    chk("exec_reset", 16'(u_if.exec_reset), 16'(m_state == S_RST));
    @(posedge clk);
    model_step(rst, p, i);
    #1;
    chk("ucc_state", 16'(u_if.ucc_state), 16'(m_state));
  endtask

  function automatic void add(input logic r, input logic i, input logic [15:0] p,
                              input logic [1:0] s, input logic e);
    vec_t v;
    v.rst = r; v.irq = i; v.pc = p; v.st = s; v.ex = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] p;
    logic        r, i;

    add(1, 0, 16'h0000, S_RST, 1); add(0, 0, 16'h0000, S_NOT, 0);
    // legal run
    add(0, 0, 16'hC000, S_NOT, 0); add(0, 0, 16'hE000, S_IN, 0);
    add(0, 0, 16'hE002, S_IN, 0);  add(0, 0, 16'hE0FE, S_IN, 0);
    add(0, 0, 16'hC010, S_NOT, 0);
    // mid-region entry
    add(0, 0, 16'hE010, S_RST, 1); add(0, 0, 16'h0000, S_NOT, 0);
    // illegal exit
    add(0, 0, 16'hE000, S_IN, 0);  add(0, 0, 16'hE004, S_IN, 0);
    add(0, 0, 16'hC000, S_RST, 1); add(0, 0, 16'h0000, S_NOT, 0);
    // interrupt round trip, then a bad return with a nested irq in the ISR
    add(0, 0, 16'hE000, S_IN, 0);  add(0, 1, 16'hE020, S_IRQ, 0);
    add(0, 0, 16'hF000, S_IRQ, 0); add(0, 0, 16'hF008, S_IRQ, 0);
    add(0, 0, 16'hF010, S_IRQ, 0); add(0, 0, 16'hE020, S_IN, 0);
    add(0, 1, 16'hE020, S_IRQ, 0); add(0, 1, 16'hF004, S_IRQ, 0);
    add(0, 0, 16'hE022, S_RST, 1); add(0, 0, 16'h0000, S_NOT, 0);
    // reset mid-operation
    add(0, 0, 16'hE000, S_IN, 0);  add(1, 0, 16'hE002, S_RST, 1);
    add(0, 0, 16'h0000, S_NOT, 0);

    system_reset = 1'b1;
    u_if.pc  = 16'h0000;
    u_if.irq = 1'b0;
    set_bounds(16'hE000, 16'hE0FE);
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      cycle(vecs[k].rst, vecs[k].pc, vecs[k].irq);
      chk($sformatf("vec%0d_state", k), 16'(u_if.ucc_state), 16'(vecs[k].st));
      chk($sformatf("vec%0d_exec", k), 16'(u_if.exec_reset), 16'(vecs[k].ex));
    end

    // prev_pc is zero right after reset
    cycle(1, 16'hE000, 1'b0);
    cycle(0, 16'hE002, 1'b0);
    chk("post_reset_inst_changed_seen", 16'(m_prev), 16'hE002);

    // single-instruction region
    cycle(1, 16'h0000, 1'b0);
    set_bounds(16'hE000, 16'hE000);
    cycle(0, 16'h0000, 1'b0);
    cycle(0, 16'hE000, 1'b0);
    chk("single_entry", 16'(u_if.ucc_state), 16'(S_IN));
    cycle(0, 16'hC000, 1'b0);
    chk("single_exit", 16'(u_if.ucc_state), 16'(S_NOT));

    // inverted bounds: every pc is outside
    set_bounds(16'hE100, 16'hE000);
    for (int k = 0; k < 6; k++) begin
      p = (k == 0) ? 16'hE000 : (k == 1) ? 16'hE100 : (k == 2) ? 16'hE080 :
          (k == 3) ? 16'h0000 : (k == 4) ? 16'hFFFF : 16'($urandom);
      u_if.pc = p;
      #1;
      chk("empty_region_outside", 16'(u_if.outside_ucc), 16'h0001);
    end

    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) begin
        p = 16'hE000 + 16'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) set_bounds(p, p);
        else set_bounds(p, p + 16'($urandom_range(1, 24)));
      end
      case ($urandom_range(0, 7))
        0:       p = b_min;
        1:       p = b_max;
        2:       p = m_saved;
        3:       p = 16'h0000;
        4, 5:    p = b_min + 16'($urandom_range(0, 32'(b_max - b_min)));
        default: p = 16'($urandom_range(16'hC000, 16'hFFFF));
      endcase
      r = ($urandom_range(0, 60) == 0);
      i = ($urandom_range(0, 3) == 0);
      cycle(r, p, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucc_entry_fsm.md
UCC_ENTRY_FSM -- requirements
Module: ucc_entry_fsm

Interface
REQ-001 SHALL have parameter RESET_HANDLER, default 16'h0000, giving the reset vector address that releases the RST state.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port system_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port pc, input, 16 bits: current program counter.
REQ-005 SHALL have port irq, input, 1 bit: interrupt accepted by the CPU this cycle.
REQ-006 SHALL have ports ucc_min and ucc_max, input, 16 bits each: inclusive UCC region bounds; these are static during operation.
REQ-007 SHALL have port ucc_state, output, 2 bits: FSM state, encoded notUCC=00, inUCC=01, IRQ=10, RST=11.
REQ-008 SHALL have port outside_ucc, output, 1 bit: pc lies outside [ucc_min, ucc_max].
REQ-009 SHALL have port inst_changed, output, 1 bit: pc differs from its value in the previous cycle.
REQ-010 SHALL have port exec_reset, output, 1 bit: UCC execution violation, high while in RST.

Function
REQ-011 SHALL compute outside_ucc combinationally as (pc < ucc_min) | (pc > ucc_max), with unsigned compares.
REQ-012 SHALL treat ucc_min > ucc_max as an empty region, so outside_ucc=1 for every pc.
REQ-013 SHALL register prev_pc <= pc every cycle and drive inst_changed = (pc != prev_pc) combinationally.
REQ-014 SHALL, in notUCC:
- go to inUCC when !outside_ucc and pc == ucc_min (the only legal entry);
- go to RST when !outside_ucc and pc != ucc_min;
- otherwise stay in notUCC.
REQ-015 SHALL, in inUCC, evaluate transitions in this priority:
- (a) outside_ucc and prev_pc != ucc_max goes to RST (illegal exit);
- (b) outside_ucc and prev_pc == ucc_max goes to notUCC (legal exit);
- (c) irq goes to IRQ and captures saved_pc <= pc;
- (d) otherwise stay in inUCC.
REQ-016 SHALL, in IRQ:
- stay while outside_ucc (ISR running);
- go to inUCC when !outside_ucc and pc == saved_pc;
- go to RST when !outside_ucc and pc != saved_pc.
REQ-017 SHALL, in IRQ, ignore further irq assertions (nested interrupts) and leave saved_pc unchanged.
REQ-018 SHALL, in RST, go to notUCC only when pc == RESET_HANDLER, and otherwise stay in RST.
REQ-019 SHALL drive exec_reset = (ucc_state == RST) combinationally from the state register.
REQ-020 SHALL, when ucc_min == ucc_max (single-instruction region), allow entry and exit through that same address: notUCC to inUCC on pc==ucc_min, then inUCC to notUCC on the next outside pc.
REQ-021 SHALL give every state transition a latency of exactly one clock after the qualifying pc is presented.
REQ-022 SHALL keep ucc_state at RST and never decode it back to another state when the state register holds an encoding outside the four defined states.

Reset
REQ-023 SHALL, on system_reset=1 at a clock edge, load ucc_state=RST, prev_pc=16'h0000 and saved_pc=16'h0000.
REQ-024 SHALL take system_reset with priority over every transition, including reset asserted mid-UCC or mid-IRQ.
REQ-025 SHALL, because prev_pc resets to 0, drive exec_reset=1 and inst_changed=(pc!=0) in the cycle after reset; outside_ucc follows pc directly.
REQ-026 SHALL give registers these initial values for simulation: ucc_state=RST and all others 0.

Structure
REQ-027 SHALL take the state encodings (notUCC, inUCC, IRQ, RST) from the shared package ucca_pkg, where the downstream stack monitor also uses them.
REQ-028 SHALL take the RESET_HANDLER default from the same package ucca_pkg.
REQ-029 SHALL use one sub-module, ucc_region_cmp, a combinational bounds compare that produces outside_ucc; everything else stays in a single FSM block.

Verification
REQ-030 SHALL verify legal run: ucc_min=16'hE000, ucc_max=16'hE0FE; pc sequence C000, E000, E002, E0FE, C010 -> ucc_state 00, 01, 01, 01, 00; exec_reset stays 0.
REQ-031 SHALL verify mid-region entry: from notUCC, pc=16'hE010 -> next cycle ucc_state=11 and exec_reset=1; then pc=16'h0000 -> ucc_state=00.
REQ-032 SHALL verify illegal exit: inUCC with prev_pc=16'hE004 then pc=16'hC000 -> ucc_state=11.
REQ-033 SHALL verify interrupt round trip:
- irq=1 at pc=16'hE020 -> ucc_state=10;
- ISR pcs F000..F010 keep ucc_state=10;
- return to pc E020 -> ucc_state=01;
- repeat with return to E022 -> ucc_state=11.
REQ-034 SHALL verify reset mid-operation: system_reset=1 while inUCC -> next edge ucc_state=11, prev_pc=0; deassert with pc=16'h0000 -> ucc_state=00 one cycle later.
REQ-035 SHALL verify degenerate bounds:
- ucc_min=ucc_max=16'hE000: pc E000 then C000 gives states 01 then 00;
- ucc_min=16'hE100, ucc_max=16'hE000: outside_ucc=1 for all pc.
